// File: rtl/conv_pkg.sv
// Shared state encoding, stride encoding and arithmetic helpers for the row convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        LOAD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Only 2'd2 selects stride 2; every other code means stride 1.
    localparam logic [1:0] STRIDE_2 = 2'd2;

    function automatic int out_cols(input int img_w, input int k, input int s);
        return (img_w - k) / s + 1;
    endfunction

    function automatic int span_cols(input int k, input int lanes, input int s);
        return k + (lanes - 1) * s;
    endfunction

    function automatic logic [31:0] requant(input logic signed [63:0] acc,
                                            input int shift, input int data_w);
        logic signed [63:0] v;
        logic signed [63:0] top;
        v   = acc >>> shift;
        top = (64'sd1 <<< data_w) - 64'sd1;
        if (v < 0)   return '0;
        if (v > top) return top[31:0];
        return v[31:0];
    endfunction

endpackage

// File: rtl/conv_col_shreg.sv
// Column shift register: columns move toward index 0, the new column lands at index tail,
// so logical column i of the current window is always entry i.
module conv_col_shreg #(
    parameter int DEPTH = 5,
    parameter int COL_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       shift_en,
    input  logic                       zero_in,
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [COL_W-1:0]           col_in,
    output logic [DEPTH*COL_W-1:0]     cols
);

    logic [COL_W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i < int'(tail)) sr_q[i] <= sr_q[i+1];
            end
            sr_q[tail] <= zero_in ? '0 : col_in;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) cols[i*COL_W +: COL_W] = sr_q[i];
    end

endmodule

// File: rtl/conv_row_engine.sv
// KxK convolution producing one output row per start, LANES windows in parallel.
// Optional CONV_BIAS_EN adds a signed bias port preloaded into the accumulators.
module conv_row_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K      = 3,
    parameter int LANES  = 2,
    parameter int IMG_W  = 28,
    parameter int SHIFT  = 0,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                stride,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [K*DATA_W-1:0]       col_in,
    input  logic                      col_valid,
    output logic                      col_ready,
    output logic [$clog2(K*K)-1:0]    kernel_addr,
    input  logic [DATA_W-1:0]         kernel_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy,
    output logic                      done
`ifdef CONV_BIAS_EN
    ,
    input  logic [ACC_W-1:0]          bias
`endif
);

    localparam int SPAN1 = span_cols(K, LANES, 1);
    localparam int SPAN2 = span_cols(K, LANES, 2);
    localparam int OC1   = out_cols(IMG_W, K, 1);
    localparam int OC2   = out_cols(IMG_W, K, 2);
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int TW    = $clog2(K * K);
    localparam int RW    = $clog2(K);
    localparam int DW    = $clog2(SPAN2);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int COL_W = K * DATA_W;

    state_t              state_q, state_d;
    logic                stride2_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CW-1:0]       accepted_q, shift_cnt_q, emitted_q;
    logic [TW-1:0]       tap_q;
    logic [RW-1:0]       kr_q, kc_q;
    logic [LW-1:0]       lane_q;
    logic [ACC_W-1:0]    acc_q [LANES];

    logic [CW-1:0]       span_c, oc_c, adv_c;
    logic                shift_en, zero_in, col_hs, out_hs;
    logic                last_fill, last_load, last_tap, last_lane, last_out;
    logic [ACC_W-1:0]    preload;
    logic [SPAN2*COL_W-1:0] cols_flat;
    logic [DATA_W-1:0]   pix  [LANES];
    logic signed [ACC_W-1:0] prod [LANES];

`ifdef CONV_BIAS_EN
    assign preload = bias;
`else
    assign preload = '0;
`endif

    assign span_c    = stride2_q ? CW'(SPAN2) : CW'(SPAN1);
    assign oc_c      = stride2_q ? CW'(OC2) : CW'(OC1);
    assign adv_c     = stride2_q ? CW'(LANES * 2) : CW'(LANES);
    assign col_hs    = col_valid & col_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_fill = shift_en && (shift_cnt_q == span_c - CW'(1));
    assign last_load = shift_en && (shift_cnt_q == adv_c - CW'(1));
    assign last_tap  = (tap_q == TW'(K * K - 1));
    assign last_out  = (emitted_q + CW'(1) == oc_c);
    assign last_lane = (lane_q == LW'(LANES - 1)) || last_out;

    conv_col_shreg #(.DEPTH(SPAN2), .COL_W(COL_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .zero_in  (zero_in),
        .tail     (DW'(span_c - CW'(1))),
        .col_in   (col_in),
        .cols     (cols_flat)
    );

    // Lane L reads window column L*S + kc, pixel row kr; pixels are unsigned, taps signed.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pix[l]  = cols_flat[(((stride2_q ? 2 * l : l) + int'(kc_q)) * K + int'(kr_q)) * DATA_W +: DATA_W];
            prod[l] = ACC_W'($signed({1'b0, pix[l]})) * ACC_W'($signed(kernel_in));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (last_fill) state_d = MAC;
            MAC:     if (last_tap) state_d = DRAIN;
            DRAIN:   if (out_hs && last_lane) state_d = last_out ? DONE : LOAD;
            LOAD:    if (last_load) state_d = MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_ready   = 1'b0;
        shift_en    = 1'b0;
        zero_in     = 1'b0;
        kernel_addr = '0;
        out_valid   = 1'b0;
        out_addr    = '0;
        out_data    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            FILL: begin
                busy      = 1'b1;
                col_ready = 1'b1;
                shift_en  = col_hs;
            end
            MAC: begin
                busy        = 1'b1;
                kernel_addr = tap_q;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = base_q + ADDR_W'(emitted_q);
                out_data  = DATA_W'(requant(64'($signed(acc_q[lane_q])), SHIFT, DATA_W));
            end
            LOAD: begin
                busy = 1'b1;
                // Past the row's last column, zero columns keep the lanes aligned.
                if (accepted_q < CW'(IMG_W)) begin
                    col_ready = 1'b1;
                    shift_en  = col_hs;
                end else begin
                    shift_en = 1'b1;
                    zero_in  = 1'b1;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride2_q   <= 1'b0;
            base_q      <= '0;
            accepted_q  <= '0;
            shift_cnt_q <= '0;
            emitted_q   <= '0;
            tap_q       <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            lane_q      <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    stride2_q   <= (stride == STRIDE_2);
                    base_q      <= base_addr;
                    accepted_q  <= '0;
                    shift_cnt_q <= '0;
                    emitted_q   <= '0;
                    lane_q      <= '0;
                end
                FILL, LOAD: begin
                    if (col_hs) accepted_q <= accepted_q + CW'(1);
                    if ((state_q == FILL) ? last_fill : last_load) begin
                        shift_cnt_q <= '0;
                        tap_q       <= '0;
                        kr_q        <= '0;
                        kc_q        <= '0;
                        for (int l = 0; l < LANES; l++) acc_q[l] <= preload;
                    end else if (shift_en) begin
                        shift_cnt_q <= shift_cnt_q + CW'(1);
                    end
                end
                MAC: begin
                    tap_q <= tap_q + TW'(1);
                    if (kc_q == RW'(K - 1)) begin
                        kc_q <= '0;
                        kr_q <= kr_q + RW'(1);
                    end else begin
                        kc_q <= kc_q + RW'(1);
                    end
                    for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + prod[l];
                end
                DRAIN: if (out_hs) begin
                    emitted_q <= emitted_q + CW'(1);
                    if (last_lane) begin
                        lane_q <= '0;
                        for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                    end else begin
                        lane_q <= lane_q + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_engine.sv
// Bench for conv_row_engine: directed patterns plus randomized rows with input gaps and output stalls.
module tb_conv_row_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int K      = 3;
    localparam int LANES  = 2;
    localparam int IMG_W  = 28;
    localparam int SHIFT  = 0;
    localparam int ADDR_W = 5;
    localparam int TW     = $clog2(K * K);
    localparam int BUDGET = 4000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [1:0]             stride = 2'd0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic [K*DATA_W-1:0]    col_in = '0;
    logic                   col_valid = 1'b0;
    logic                   col_ready;
    logic [TW-1:0]          kernel_addr;
    logic [DATA_W-1:0]      kernel_in;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [ADDR_W-1:0]      out_addr;
    logic [DATA_W-1:0]      out_data;
    logic                   busy;
    logic                   done;

    int total = 0;
    int bad   = 0;
    int pix [K][IMG_W];
    logic [DATA_W-1:0] taps [2**TW];
    int bias_v = 0;

    always #5 clk = ~clk;
    assign kernel_in = taps[kernel_addr];

`ifdef CONV_BIAS_EN
    logic [ACC_W-1:0] bias;
    assign bias = ACC_W'(bias_v);
`endif

    conv_row_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .K(K), .LANES(LANES),
        .IMG_W(IMG_W), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stride      (stride),
        .base_addr   (base_addr),
        .col_in      (col_in),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .kernel_addr (kernel_addr),
        .kernel_in   (kernel_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
`ifdef CONV_BIAS_EN
        ,
        .bias        (bias)
`endif
    );

    task automatic chk(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_col_ready"}, col_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_kernel_addr"}, kernel_addr, 0);
    endtask

    // Reference: direct KxK dot product at input column j*s, wrapped to ACC_W, shifted, clamped.
    function automatic int model_out(input int s, input int j);
        longint sum;
        longint m;
        sum = bias_v;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                sum += longint'(pix[r][j*s + c]) * longint'($signed(taps[r*K + c]));
        m = sum & ((64'sd1 <<< ACC_W) - 1);
        if (m >= (64'sd1 <<< (ACC_W - 1))) m -= (64'sd1 <<< ACC_W);
        m = m >>> SHIFT;
        if (m < 0) return 0;
        if (m > (1 << DATA_W) - 1) return (1 << DATA_W) - 1;
        return int'(m);
    endfunction

    function automatic logic [K*DATA_W-1:0] column(input int c);
        logic [K*DATA_W-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++) v[r*DATA_W +: DATA_W] = DATA_W'(pix[r][c]);
        return v;
    endfunction

    function automatic logic [1:0] stride_code(input int s);
        int pick;
        if (s == 2) return 2'd2;
        pick = $urandom_range(0, 2);
        return (pick == 0) ? 2'd0 : ((pick == 1) ? 2'd1 : 2'd3);
    endfunction

    task automatic run_row(input int s, input int base, input bit gaps, input bit stall, input bit abort);
        int  exp_q [$];
        int  oc, span, sent, idx, dones, t_span, t_first;
        bit  fin, held;
        logic [DATA_W-1:0] hd;
        logic [ADDR_W-1:0] ha;
        oc   = (IMG_W - K) / s + 1;
        span = K + (LANES - 1) * s;
        for (int j = 0; j < oc; j++) exp_q.push_back(model_out(s, j));
        sent = 0; idx = 0; dones = 0; t_span = -1; t_first = -1; fin = 0; held = 0;
        hd = '0; ha = '0;

        @(posedge clk); #1;
        stride    = stride_code(s);
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;

        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            @(negedge clk);
            if (col_valid && col_ready) begin
                sent++;
                if (sent == span) t_span = cyc;
            end
            if (out_valid) begin
                if (t_first < 0) t_first = cyc;
                if (held) begin
                    chk("hold_data", out_data, hd);
                    chk("hold_addr", out_addr, ha);
                end
                if (out_ready) begin
                    if (idx < oc) begin
                        chk($sformatf("data[%0d]", idx), out_data, exp_q[idx]);
                        chk($sformatf("addr[%0d]", idx), out_addr, (base + idx) % (1 << ADDR_W));
                    end else begin
                        chk("extra_output", idx, oc);
                    end
                    idx++;
                    held = 0;
                end else begin
                    held = 1; hd = out_data; ha = out_addr;
                end
            end
            if (done) begin
                dones++;
                fin = 1;
            end
            if (abort && idx == 2 * LANES && kernel_addr == TW'(K * K / 2)) begin
                rst = 1'b1;
                #1;
                chk_idle("abort");
                col_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                end
                rst = 1'b0;
                return;
            end
            if (!fin) begin
                @(posedge clk); #1;
                col_valid = !gaps || ($urandom_range(0, 3) != 0);
                col_in    = (sent < IMG_W) ? column(sent) : K*DATA_W'($urandom);
                out_ready = !stall || ($urandom_range(0, 2) == 0);
                stride    = 2'($urandom_range(0, 3));
                base_addr = ADDR_W'($urandom);
                start     = stall && (idx < oc - LANES) && ($urandom_range(0, 7) == 0);
            end
        end

        chk("row_finished", fin, 1);
        chk("outputs", idx, oc);
        chk("cols_accepted", sent, IMG_W);
        chk("done_pulses", dones, 1);
        chk("first_latency", t_first - t_span, K * K + 1);
        @(posedge clk); #1;
        col_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_col_ready", col_ready, 0);
        col_valid = 1'b0;
    endtask

    task automatic set_pix_const(input int v);
        for (int r = 0; r < K; r++) for (int c = 0; c < IMG_W; c++) pix[r][c] = v;
    endtask

    task automatic set_taps_const(input int v);
        for (int i = 0; i < 2**TW; i++) taps[i] = (i < K * K) ? DATA_W'(v) : '0;
    endtask

    task automatic set_random();
        for (int r = 0; r < K; r++) for (int c = 0; c < IMG_W; c++) pix[r][c] = $urandom_range(0, 40);
        for (int i = 0; i < 2**TW; i++) taps[i] = (i < K * K) ? DATA_W'($urandom_range(0, 8) - 4) : '0;
    endtask

    initial begin
        set_pix_const(0);
        set_taps_const(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

`ifdef CONV_BIAS_EN
        bias_v = -5;
`endif
        set_pix_const(1);
        set_taps_const(1);
        run_row(1, 3, 0, 0, 0);
        bias_v = 0;

        for (int r = 0; r < K; r++) for (int c = 0; c < IMG_W; c++) pix[r][c] = c;
        set_taps_const(0);
        taps[K + 1] = 8'd1;
        run_row(2, 0, 0, 0, 0);

        set_pix_const(255);
        set_taps_const(1);
        run_row(1, 30, 1, 0, 0);
        set_taps_const(-1);
        run_row(2, 7, 0, 0, 0);

        for (int it = 0; it < 4; it++) begin
            set_random();
`ifdef CONV_BIAS_EN
            bias_v = $urandom_range(0, 200) - 100;
`endif
            run_row($urandom_range(1, 2), $urandom_range(0, 31), 1, 1, 0);
        end

        set_random();
        run_row(1, 5, 0, 0, 1);
        run_row(1, 5, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
